// File: rtl/dpram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_ctrl
//  Purpose  : Single-clock true-dual-port RAM front end. Sits between user
//             logic and an external RAM macro and adds:
//               - a post-reset clear sweep writing InitValue to every word,
//               - per-port read-valid strobes matched to the macro latency,
//               - write/write collision arbitration (port A wins),
//               - optional write-first forwarding across ports.
//  Options  : DPRAM_BYPASS_EN - when defined, a read on one port and a write
//             on the other port to the same in-range address in the same
//             cycle returns the newly written word.
//  Ports    : clock, aclr (sync, active high)
//             address_x, data_x, rden_x, wren_x  - user requests (x = a, b)
//             q_x, qvalid_x                      - read data + 1-cycle strobe
//             ready                              - clear sweep finished
//             collision                          - write/write arbitrated
//             clk, ena/wea/addra/dina, douta     - macro port A
//             enb/web/addrb/dinb, doutb          - macro port B
//  Revision : 1.0 - initial release
// ============================================================================
module dpram_ctrl #(
    parameter int                   DataWidth    = 32,
    parameter int                   DataDepth    = 4,
    parameter int                   RAMAddWidth  = 2,
    parameter int                   MacroLatency = 1,
    parameter logic [DataWidth-1:0] InitValue    = '0
) (
    input  logic                   clock,
    input  logic                   aclr,
    // user port A
    input  logic [RAMAddWidth-1:0] address_a,
    input  logic [DataWidth-1:0]   data_a,
    input  logic                   rden_a,
    input  logic                   wren_a,
    output logic [DataWidth-1:0]   q_a,
    output logic                   qvalid_a,
    // user port B
    input  logic [RAMAddWidth-1:0] address_b,
    input  logic [DataWidth-1:0]   data_b,
    input  logic                   rden_b,
    input  logic                   wren_b,
    output logic [DataWidth-1:0]   q_b,
    output logic                   qvalid_b,
    // status
    output logic                   ready,
    output logic                   collision,
    // macro interface
    output logic                   clk,
    output logic                   ena,
    output logic                   wea,
    output logic [RAMAddWidth-1:0] addra,
    output logic [DataWidth-1:0]   dina,
    input  logic [DataWidth-1:0]   douta,
    output logic                   enb,
    output logic                   web,
    output logic [RAMAddWidth-1:0] addrb,
    output logic [DataWidth-1:0]   dinb,
    input  logic [DataWidth-1:0]   doutb
);

    // Depth held one bit wider than the address so that DataDepth equal to
    // 2^RAMAddWidth is representable and the range compare never wraps.
    localparam logic [RAMAddWidth:0] c_depth = (RAMAddWidth + 1)'(DataDepth);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [RAMAddWidth:0]   r_sweep_cnt;
    logic                   w_sweep_active;
    logic                   w_ready;

    logic                   w_inrange_a;
    logic                   w_inrange_b;
    logic                   w_en_a;
    logic                   w_en_b;
    logic                   w_wr_a;
    logic                   w_wr_b_req;
    logic                   w_wr_b;
    logic                   w_rd_a;
    logic                   w_rd_b;
    logic                   w_collide;
    logic                   r_collision;

    logic                   r_rd_pipe_a [MacroLatency];
    logic                   r_rd_pipe_b [MacroLatency];
    logic [DataWidth-1:0]   w_load_a;
    logic [DataWidth-1:0]   w_load_b;
    logic [DataWidth-1:0]   r_q_a;
    logic [DataWidth-1:0]   r_q_b;
    logic                   r_qvalid_a;
    logic                   r_qvalid_b;

    assign clk = clock;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_ready     = (r_state == ST_READY);
    assign w_inrange_a = ({1'b0, address_a} < c_depth);
    assign w_inrange_b = ({1'b0, address_b} < c_depth);

    assign w_en_a      = w_ready & (rden_a | wren_a) & w_inrange_a;
    assign w_en_b      = w_ready & (rden_b | wren_b) & w_inrange_b;

    // A write on the same port swallows a simultaneous read.
    assign w_wr_a      = w_ready & wren_a & w_inrange_a;
    assign w_wr_b_req  = w_ready & wren_b & w_inrange_b;
    assign w_rd_a      = w_ready & rden_a & ~wren_a & w_inrange_a;
    assign w_rd_b      = w_ready & rden_b & ~wren_b & w_inrange_b;

    // Port A owns a contested address; port B's write is dropped.
    assign w_collide   = w_wr_a & w_wr_b_req & (address_a == address_b);
    assign w_wr_b      = w_wr_b_req & ~w_collide;

    // The sweep stays in CLEAR for one idle cycle after the last word so
    // that ready rises exactly DataDepth edges after reset release.
    assign w_sweep_active = (r_sweep_cnt != c_depth);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR && w_sweep_active) begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and macro drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        ena          = 1'b0;
        wea          = 1'b0;
        addra        = address_a;
        dina         = data_a;
        enb          = 1'b0;
        web          = 1'b0;
        addrb        = address_b;
        dinb         = data_b;
        case (r_state)
            ST_CLEAR: begin
                ena   = w_sweep_active;
                wea   = w_sweep_active;
                addra = r_sweep_cnt[RAMAddWidth-1:0];
                dina  = InitValue;
                if (!w_sweep_active) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                ena = w_en_a;
                wea = w_wr_a;
                enb = w_en_b;
                web = w_wr_b;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-accepted pipelines, one stage per clock of macro latency
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < MacroLatency; i++) begin
                r_rd_pipe_a[i] <= 1'b0;
                r_rd_pipe_b[i] <= 1'b0;
            end
        end else begin
            r_rd_pipe_a[0] <= w_rd_a;
            r_rd_pipe_b[0] <= w_rd_b;
            for (int i = 1; i < MacroLatency; i++) begin
                r_rd_pipe_a[i] <= r_rd_pipe_a[i-1];
                r_rd_pipe_b[i] <= r_rd_pipe_b[i-1];
            end
        end
    end

`ifdef DPRAM_BYPASS_EN
    // ------------------------------------------------------------------
    // Cross-port write-first forwarding: the opposite port's write data
    // travels beside the read flag and replaces the macro output.
    // ------------------------------------------------------------------
    logic                 w_fwd_a;
    logic                 w_fwd_b;
    logic                 r_fwd_pipe_a [MacroLatency];
    logic                 r_fwd_pipe_b [MacroLatency];
    logic [DataWidth-1:0] r_fwd_data_a [MacroLatency];
    logic [DataWidth-1:0] r_fwd_data_b [MacroLatency];

    assign w_fwd_a = w_rd_a & w_wr_b & (address_a == address_b);
    assign w_fwd_b = w_rd_b & w_wr_a & (address_a == address_b);

    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < MacroLatency; i++) begin
                r_fwd_pipe_a[i] <= 1'b0;
                r_fwd_pipe_b[i] <= 1'b0;
                r_fwd_data_a[i] <= '0;
                r_fwd_data_b[i] <= '0;
            end
        end else begin
            r_fwd_pipe_a[0] <= w_fwd_a;
            r_fwd_pipe_b[0] <= w_fwd_b;
            r_fwd_data_a[0] <= data_b;
            r_fwd_data_b[0] <= data_a;
            for (int i = 1; i < MacroLatency; i++) begin
                r_fwd_pipe_a[i] <= r_fwd_pipe_a[i-1];
                r_fwd_pipe_b[i] <= r_fwd_pipe_b[i-1];
                r_fwd_data_a[i] <= r_fwd_data_a[i-1];
                r_fwd_data_b[i] <= r_fwd_data_b[i-1];
            end
        end
    end

    assign w_load_a = r_fwd_pipe_a[MacroLatency-1] ? r_fwd_data_a[MacroLatency-1] : douta;
    assign w_load_b = r_fwd_pipe_b[MacroLatency-1] ? r_fwd_data_b[MacroLatency-1] : doutb;
`else
    assign w_load_a = douta;
    assign w_load_b = doutb;
`endif

    // ------------------------------------------------------------------
    // Output registers: load only on the strobe, otherwise hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_q_a       <= '0;
            r_q_b       <= '0;
            r_qvalid_a  <= 1'b0;
            r_qvalid_b  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_qvalid_a  <= r_rd_pipe_a[MacroLatency-1];
            r_qvalid_b  <= r_rd_pipe_b[MacroLatency-1];
            r_collision <= w_collide;
            if (r_rd_pipe_a[MacroLatency-1]) begin
                r_q_a <= w_load_a;
            end
            if (r_rd_pipe_b[MacroLatency-1]) begin
                r_q_b <= w_load_b;
            end
        end
    end

    assign q_a       = r_q_a;
    assign q_b       = r_q_b;
    assign qvalid_a  = r_qvalid_a;
    assign qvalid_b  = r_qvalid_b;
    assign collision = r_collision;
    assign ready     = w_ready;

endmodule
`default_nettype wire

// File: doc/dpram_ctrl.md
# dpram_ctrl

Single-clock, parametrised true-dual-port RAM controller between user logic and an external RAM macro. It adds four behaviours to the plain pass-through wrapper:
- a post-reset clear sweep that writes every location;
- per-port read-valid strobes aligned to a configurable macro read latency;
- deterministic write/write collision arbitration;
- optional write-first forwarding across ports.

It is the standard on-chip RAM front end for the sketch and counter arrays.

## Interface
Parameters:
- DataWidth, 32, data word width
- DataDepth, 4, number of words (any value >=2; need not be a power of two)
- RAMAddWidth, 2, address width; must satisfy 2^RAMAddWidth >= DataDepth
- MacroLatency, 1, macro read latency in clocks (1..4)
- InitValue, 0, word written to every location by the clear sweep

Ports:
- clock  in  1  sole clock; also drives macro clk
- aclr  in  1  synchronous active-high reset
- address_a / address_b  in  RAMAddWidth  port A / port B address
- data_a / data_b  in  DataWidth  write data
- rden_a / rden_b  in  1  read request
- wren_a / wren_b  in  1  write request
- q_a / q_b  out  DataWidth  registered read data
- qvalid_a / qvalid_b  out  1  one-cycle strobe; q_x holds new read data
- ready  out  1  high once the clear sweep is complete
- collision  out  1  one-cycle pulse: write/write to the same address was arbitrated
- clk  out  1  = clock
- ena, wea, addra, dina  out  macro port A controls
- douta  in  DataWidth  macro port A data
- enb, web, addrb, dinb  out  macro port B controls
- doutb  in  DataWidth  macro port B data

## Operation
- FSM has two states, CLEAR and READY.
  - aclr forces CLEAR and sets counter to 0.
  - CLEAR:
    - Macro port A is driven with ena=wea=1, addra=counter, dina=InitValue; macro port B is idle.
    - Counter increments each cycle.
    - Leave for READY in the cycle after counter==DataDepth-1.
    - All user requests are ignored; no qvalid is produced.
  - READY: user ports drive the macro combinationally.
    - ena=(rden_a|wren_a)&inrange_a; wea=wren_a&inrange_a. Port B is analogous.
- Out-of-range addresses (address >= DataDepth) are dropped: enable low, no qvalid, no write.
- Same-port rden and wren together: the write wins; the read is discarded.
- Write/write to the same in-range address: port A wins.
  - web is forced low.
  - collision pulses one cycle later.
- Read pipeline:
  - Per port, a MacroLatency-deep shift register carries the read-accepted flag.
  - q_x is loaded from dout_x when the flag reaches the last stage, with qvalid_x=1 that cycle.
  - Otherwise q_x holds its value and qvalid_x=0.
- Reset values:
  - q_a, q_b = 0.
  - qvalid_a, qvalid_b, ready, collision = 0.
  - Read and forward pipelines are flushed.
  - Macro ena=wea=1 at addra=0 during the first CLEAR cycle; enb=web=0.
- aclr mid-operation:
  - In-flight reads are discarded and never strobe.
  - The sweep restarts from address 0.

## Timing
- Request sampled at edge N → q_x/qvalid_x valid after edge N+MacroLatency.
- Full throughput: one request per port per clock, no back-pressure.
- aclr deasserted before edge 0 → ready rises after edge DataDepth; the first user request is accepted at edge DataDepth+1.
- collision is asserted the cycle after the conflicting request.

## Configuration
- DPRAM_BYPASS_EN defined:
  - Trigger: a read on one port and a write on the other port, to the same in-range address in the same cycle.
  - Action: the write data and a forward flag are pushed down a MacroLatency-deep pipeline alongside the read flag.
  - Result: q_x returns the newly written word (write-first) regardless of macro behaviour.
- Not defined:
  - No forwarding logic; q_x is whatever the macro returns for that case.
  - All other behaviour is identical.

## Test plan
- Reset sweep:
  - Stimulus: DataDepth=6, InitValue=0xA5A5A5A5, aclr for 2 cycles.
  - Required: ready rises exactly 6 clocks after release; each addra 0..5 written once; reads of all 6 addresses return 0xA5A5A5A5.
- Latency:
  - Stimulus: MacroLatency=2; write 0x11 to addr 3 on A; next cycle rden_b at addr 3.
  - Required: qvalid_b pulses 2 cycles after the read; q_b=0x11.
- Write/write collision:
  - Stimulus: wren_a and wren_b to addr 1 with data 0x22 and 0x33.
  - Required: web=0, collision pulses next cycle, a later read of addr 1 returns 0x22.
- Forwarding:
  - Stimulus: write 0x44 on A and read on B, both to addr 2, same cycle.
  - Required: with DPRAM_BYPASS_EN, q_b=0x44 on the qvalid_b strobe; without it, the bench accepts macro output.
- Out-of-range and same-port conflict:
  - Stimulus: read at addr 7 with DataDepth=6; rden_a and wren_a together with data 0x55.
  - Required: no qvalid for either request; the location receives 0x55.
- Mid-operation reset:
  - Stimulus: aclr asserted one cycle after an accepted read.
  - Required: no qvalid, q_a=0, ready low, and the sweep restarts at addra=0.
